// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the UART boot sequencer: state encoding and the
// default end-of-image marker.
package boot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } boot_state_e;

    localparam logic [31:0] END_MARK_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/boot_timeout_cnt.sv
// Clearable, enabled up-counter that saturates at LIMIT-1 and flags the
// terminal count. Used for both the inter-word timeout and the reset hold.
module boot_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned      CW      = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(LIMIT - 1);
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    assign tc = (cnt_r == LAST);

    // Count enabled cycles; clear has priority; hold once terminal is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && !tc) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot sequencer: streams loader words into IMEM while the core is held in
// reset, detects end marker / timeout / overflow, then releases the core and
// hands the IMEM port to instruction fetch.
module uart_boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int unsigned    DW          = 32,
    parameter int unsigned    IMEM_AW     = 12,
    parameter logic [DW-1:0]  END_MARK    = DW'(END_MARK_DEFAULT),
    parameter int unsigned    TIMEOUT_CYC = 50_000_000,
    parameter int unsigned    RST_HOLD    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      ld_inst,
    input  logic               ld_valid,
    input  logic               boot_req,
    input  logic               run_req,
    input  logic [31:0]        cpu_fetch_addr,
    input  logic               cpu_fetch_en,
    output logic               imem_we,
    output logic               imem_re,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DW-1:0]      imem_wdata,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               load_err,
    output logic [IMEM_AW:0]   word_count
);

    localparam logic [IMEM_AW:0] FULL_CNT = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] WC_ONE   = {{IMEM_AW{1'b0}}, 1'b1};

    boot_state_e          state_r;
    boot_state_e          state_nxt_s;
    logic                 write_s;
    logic                 mark_s;
    logic                 clear_s;
    logic                 is_mark_s;
    logic                 full_s;
    logic                 to_tc_s;
    logic                 hold_tc_s;
    logic                 img_ok_r;
    logic                 we_r;
    logic [IMEM_AW-1:0]   wr_addr_r;
    logic [DW-1:0]        wdata_r;
    logic [IMEM_AW:0]     word_count_r;
    logic                 cpu_rst_r;
    logic                 load_done_r;
    logic                 load_err_r;
    logic                 run_s;
    logic                 fetch_unused_s;

    assign is_mark_s = (ld_inst == END_MARK);
    assign full_s    = (word_count_r == FULL_CNT);
    assign run_s     = (state_r == ST_RUN);

    // Only the word-index bits of the byte fetch address reach IMEM.
    assign fetch_unused_s = ^{cpu_fetch_addr[31:IMEM_AW+2], cpu_fetch_addr[1:0]};

    // Inter-word timeout: runs only in LOAD, restarts on every received word.
    boot_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr ((state_r != ST_LOAD) || ld_valid),
        .en  (state_r == ST_LOAD),
        .tc  (to_tc_s)
    );

    // Reset hold: counts the cycles spent in HOLD before releasing the core.
    boot_timeout_cnt #(.LIMIT(RST_HOLD)) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (state_r != ST_HOLD),
        .en  (state_r == ST_HOLD),
        .tc  (hold_tc_s)
    );

    // Next-state and write decision; boot_req overrides everything else.
    always_comb begin
        state_nxt_s = state_r;
        write_s     = 1'b0;
        mark_s      = 1'b0;
        clear_s     = 1'b0;
        if (boot_req) begin
            state_nxt_s = ST_IDLE;
            clear_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_valid) begin
                        if (is_mark_s) begin
                            state_nxt_s = ST_HOLD;
                            mark_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_LOAD;
                            write_s     = 1'b1;
                        end
                    end else if (run_req) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (is_mark_s) begin
                            state_nxt_s = ST_HOLD;
                            mark_s      = 1'b1;
                        end else if (full_s) begin
                            state_nxt_s = ST_ERROR;
                        end else begin
                            write_s     = 1'b1;
                        end
                    end else if (to_tc_s) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (hold_tc_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_RUN:   state_nxt_s = ST_RUN;
                ST_ERROR: state_nxt_s = ST_ERROR;
                default:  state_nxt_s = ST_ERROR;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Remembers whether the current image was closed by the end marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_ok_r <= 1'b0;
        end else if (clear_s) begin
            img_ok_r <= 1'b0;
        end else if (mark_s) begin
            img_ok_r <= 1'b1;
        end else begin
            img_ok_r <= img_ok_r;
        end
    end

    // Word counter; its low bits double as the IMEM write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r <= {(IMEM_AW+1){1'b0}};
        end else if (clear_s) begin
            word_count_r <= {(IMEM_AW+1){1'b0}};
        end else if (write_s) begin
            word_count_r <= word_count_r + WC_ONE;
        end else begin
            word_count_r <= word_count_r;
        end
    end

    // Registered write port: one-cycle strobe with address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r      <= 1'b0;
            wr_addr_r <= {IMEM_AW{1'b0}};
            wdata_r   <= {DW{1'b0}};
        end else if (write_s) begin
            we_r      <= 1'b1;
            wr_addr_r <= word_count_r[IMEM_AW-1:0];
            wdata_r   <= ld_inst;
        end else begin
            we_r      <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wdata_r   <= wdata_r;
        end
    end

    // Status outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            cpu_rst_r   <= (state_nxt_s != ST_RUN);
            load_done_r <= (state_nxt_s == ST_RUN) && img_ok_r && !clear_s;
            load_err_r  <= (state_nxt_s == ST_ERROR);
        end
    end

    // In RUN the fetch stage drives the port directly; otherwise the loader does.
    assign imem_we    = we_r;
    assign imem_re    = run_s ? cpu_fetch_en : 1'b0;
    assign imem_addr  = run_s ? cpu_fetch_addr[IMEM_AW+1:2] : wr_addr_r;
    assign imem_wdata = wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;
    assign word_count = word_count_r;

endmodule
